// File: rtl/pipeline_pkg.sv
// Shared types for the pipeline enable/flush controller.
// Controller states, the per-latch control bundle and the hardwired-zero register id.
package pipeline_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALTED   = 2'd2
    } ctrl_state_t;

    localparam int REG_ZERO = 0;

    typedef struct packed {
        logic en;
        logic flush;
    } latch_ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge CLK) begin
        if (clr)
            cnt <= '0;
        else if (inc && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Enable/flush controller for the 5-stage pipeline latches.
// Resolves halt, data waits, redirects, load-use and fetch misses.
module pipeline_ctrl
    import pipeline_pkg::*;
#(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ihit,
    input  logic             dhit,
    input  logic             mem_dREN,
    input  logic             mem_dWEN,
    input  logic             mem_halt,
    input  logic             branch_taken,
    input  logic             ex_dREN,
    input  logic [REG_W-1:0] ex_wsel,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    output logic             pc_en,
    output logic             fetch_en,
    output logic             decode_en,
    output logic             execute_en,
    output logic             memory_en,
    output logic             flush_fd,
    output logic             flush_de,
    output logic             flush_em,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    ctrl_state_t state, state_n;
    latch_ctrl_t fd, de, em;
    logic        stall_inc, flush_inc;
    logic        load_use, mem_busy, wait_now;

    assign load_use = ex_dREN
                   && ex_wsel != REG_W'(REG_ZERO)
                   && (ex_wsel == id_rs
                       || (id_uses_rt && ex_wsel == id_rt));

    assign mem_busy = (mem_dREN || mem_dWEN) && !dhit;
    assign wait_now = (state == RUN) ? mem_busy : !dhit;

    always_comb begin
        state_n   = state;
        pc_en     = 1'b0;
        fd        = '0;
        de        = '0;
        em        = '0;
        memory_en = 1'b0;
        halted    = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        if (RST) begin
            state_n = RUN;
        end else begin
            case (state)
                RUN, MEM_WAIT: begin
                    if (state == RUN && mem_halt) begin
                        state_n = HALTED;
                    end else if (wait_now) begin
                        state_n   = MEM_WAIT;
                        stall_inc = 1'b1;
                    end else begin
                        state_n   = RUN;
                        pc_en     = 1'b1;
                        fd.en     = 1'b1;
                        de.en     = 1'b1;
                        em.en     = 1'b1;
                        memory_en = 1'b1;
                        // a redirect squashes whatever the stall would protect
                        if (branch_taken) begin
                            fd.flush  = 1'b1;
                            de.flush  = 1'b1;
                            em.flush  = 1'b1;
                            flush_inc = 1'b1;
                        end else if (load_use) begin
                            pc_en     = 1'b0;
                            fd.en     = 1'b0;
                            de.flush  = 1'b1;
                            stall_inc = 1'b1;
                        end else if (!ihit) begin
                            pc_en     = 1'b0;
                            fd.flush  = 1'b1;
                            stall_inc = 1'b1;
                        end
                    end
                end
                HALTED: halted = 1'b1;
                default: state_n = RUN;
            endcase
        end
    end

    assign fetch_en   = fd.en;
    assign flush_fd   = fd.flush;
    assign decode_en  = de.en;
    assign flush_de   = de.flush;
    assign execute_en = em.en;
    assign flush_em   = em.flush;

    always_ff @(posedge CLK) begin
        if (RST)
            state <= RUN;
        else
            state <= state_n;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (stall_inc),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .CLK (CLK),
        .clr (RST),
        .inc (flush_inc),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl against a cycle-level reference model.
// A second instance with 2-bit counters exercises saturation.
module tb_pipeline_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, mem_halt, branch_taken;
    logic       ex_dREN, id_uses_rt;
    logic [4:0] ex_wsel, id_rs, id_rt;

    logic        pc_en, fetch_en, decode_en, execute_en, memory_en;
    logic        flush_fd, flush_de, flush_em, halted;
    logic [15:0] stall_cnt, flush_cnt;

    logic       s_pc_en, s_fetch_en, s_decode_en, s_execute_en, s_memory_en;
    logic       s_flush_fd, s_flush_de, s_flush_em, s_halted;
    logic [1:0] s_stall_cnt, s_flush_cnt;

    int errors = 0;
    int checks = 0;

    bit m_wait, m_stop;
    int m_sc, m_fc;

    always #5 CLK = ~CLK;

    pipeline_ctrl #(.REG_W(5), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .branch_taken(branch_taken), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(pc_en), .fetch_en(fetch_en), .decode_en(decode_en),
        .execute_en(execute_en), .memory_en(memory_en),
        .flush_fd(flush_fd), .flush_de(flush_de), .flush_em(flush_em),
        .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    pipeline_ctrl #(.REG_W(5), .CNT_W(2)) dut_small (
        .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .mem_halt(mem_halt),
        .branch_taken(branch_taken), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .pc_en(s_pc_en), .fetch_en(s_fetch_en), .decode_en(s_decode_en),
        .execute_en(s_execute_en), .memory_en(s_memory_en),
        .flush_fd(s_flush_fd), .flush_de(s_flush_de), .flush_em(s_flush_em),
        .halted(s_halted), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    function automatic int sat(int v, int m);
        return (v > m) ? m : v;
    endfunction

    task automatic idle();
        RST = 0; ihit = 1; dhit = 0; mem_dREN = 0; mem_dWEN = 0;
        mem_halt = 0; branch_taken = 0; ex_dREN = 0; id_uses_rt = 0;
        ex_wsel = 0; id_rs = 0; id_rt = 0;
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already set; check outputs mid-cycle,
    // then advance the model and check counters after the edge.
    task automatic step();
        logic [8:0] e, o, so;
        bit lu;
        #2;
        e = '0;
        lu = ex_dREN && ex_wsel != 0
             && (ex_wsel == id_rs || (id_uses_rt && ex_wsel == id_rt));
        if (RST) begin
            m_wait = 0; m_stop = 0; m_sc = 0; m_fc = 0;
        end else if (m_stop) begin
            e[0] = 1;
        end else if (!m_wait && mem_halt) begin
            m_stop = 1;
        end else if (m_wait ? !dhit : ((mem_dREN || mem_dWEN) && !dhit)) begin
            m_wait = 1; m_sc++;
        end else begin
            m_wait = 0;
            // order: pc fetch decode execute memory ffd fde fem halted
            if (branch_taken) begin
                e = 9'b11111_111_0; m_fc++;
            end else if (lu) begin
                e = 9'b00111_010_0; m_sc++;
            end else if (!ihit) begin
                e = 9'b01111_100_0; m_sc++;
            end else begin
                e = 9'b11111_000_0;
            end
        end
        o  = {pc_en, fetch_en, decode_en, execute_en, memory_en,
              flush_fd, flush_de, flush_em, halted};
        so = {s_pc_en, s_fetch_en, s_decode_en, s_execute_en, s_memory_en,
              s_flush_fd, s_flush_de, s_flush_em, s_halted};
        check("ctl", 64'(o), 64'(e));
        check("ctl_small", 64'(so), 64'(e));
        @(posedge CLK);
        #1;
        check("cnt", {32'd0, stall_cnt, flush_cnt},
              {32'd0, 16'(sat(m_sc, 65535)), 16'(sat(m_fc, 65535))});
        check("cnt_small", 64'({s_stall_cnt, s_flush_cnt}),
              64'({2'(sat(m_sc, 3)), 2'(sat(m_fc, 3))}));
    endtask

    initial begin
        idle();
        m_wait = 0; m_stop = 0; m_sc = 0; m_fc = 0;
        @(posedge CLK);
        #1;

        RST = 1; ihit = 1;
        step();
        step();
        RST = 0;
        step();
        check("rst_ena", 64'(stall_cnt), 64'd0);

        ex_dREN = 1; ex_wsel = 8; id_rs = 8;
        step();
        idle();
        step();
        check("lu_stall", 64'(stall_cnt), 64'd1);

        ex_dREN = 1; ex_wsel = 0; id_rs = 0;
        step();
        ex_wsel = 8; id_rs = 1; id_rt = 8; id_uses_rt = 0;
        step();
        id_uses_rt = 1;
        step();
        idle();
        check("lu_rt", 64'(stall_cnt), 64'd2);

        RST = 1;
        step();
        idle();
        mem_dREN = 1;
        repeat (3) step();
        dhit = 1;
        step();
        idle();
        check("dwait", 64'(stall_cnt), 64'd3);

        mem_dWEN = 1;
        step();
        branch_taken = 1; mem_dWEN = 0; dhit = 1;
        ex_dREN = 1; ex_wsel = 3; id_rs = 3; ihit = 0;
        step();
        idle();
        check("br_flush", 64'(flush_cnt), 64'd1);
        check("br_stall", 64'(stall_cnt), 64'd4);

        mem_halt = 1;
        step();
        idle();
        for (int i = 0; i < 6; i++) begin
            {ihit, dhit, mem_dREN, branch_taken, ex_dREN} = 5'($urandom);
            mem_halt = 1'($urandom);
            step();
        end
        check("halted", 64'(halted), 64'd1);
        idle();
        RST = 1;
        step();
        RST = 0;
        step();
        check("unhalt", 64'(halted), 64'd0);

        ihit = 0;
        repeat (5) step();
        ihit = 1;
        check("sat_small", 64'(s_stall_cnt), 64'd3);
        check("sat_big", 64'(stall_cnt), 64'd5);

        for (int i = 0; i < 3000; i++) begin
            RST          = ($urandom_range(0, 99) < 2);
            ihit         = ($urandom_range(0, 99) < 80);
            dhit         = ($urandom_range(0, 99) < 50);
            mem_dREN     = ($urandom_range(0, 99) < 15);
            mem_dWEN     = ($urandom_range(0, 99) < 10);
            mem_halt     = ($urandom_range(0, 199) < 1);
            branch_taken = ($urandom_range(0, 99) < 10);
            ex_dREN      = ($urandom_range(0, 99) < 40);
            id_uses_rt   = 1'($urandom);
            ex_wsel      = 5'($urandom_range(0, 3));
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central enable/flush controller for the 5-stage pipeline. It is the producer side of the latch-enable interface: it drives the `*_en` and `flush_*` inputs that the fetch, decode, execute and memory pipeline latches sample every cycle. It handles load-use hazards, instruction-fetch misses, data-memory waits, taken branches and jumps, and halt. It also keeps saturating stall and flush counters for the performance monitors.

Parameters:
- REG_W, 5, register-select width (`id_rs`, `id_rt`, `ex_wsel`).
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- ihit  in  1  instruction fetch completed this cycle.
- dhit  in  1  data access completed this cycle.
- mem_dREN  in  1  load in MEM stage.
- mem_dWEN  in  1  store in MEM stage.
- mem_halt  in  1  halt instruction in MEM stage.
- branch_taken  in  1  branch or jump redirect resolved in MEM stage.
- ex_dREN  in  1  instruction in EX stage is a load.
- ex_wsel  in  REG_W  destination register of the EX-stage instruction.
- id_rs  in  REG_W  source register rs of the ID-stage instruction.
- id_rt  in  REG_W  source register rt of the ID-stage instruction.
- id_uses_rt  in  1  ID-stage instruction reads rt.
- pc_en  out  1  PC register load enable.
- fetch_en  out  1  IF/ID latch enable.
- decode_en  out  1  ID/EX latch enable.
- execute_en  out  1  EX/MEM latch enable.
- memory_en  out  1  MEM/WB latch enable.
- flush_fd  out  1  IF/ID loads a bubble (nop) instead of data.
- flush_de  out  1  ID/EX loads a bubble.
- flush_em  out  1  EX/MEM loads a bubble.
- halted  out  1  pipeline permanently stopped.
- stall_cnt  out  CNT_W  cycles spent in any stall.
- flush_cnt  out  CNT_W  taken-redirect flushes.

Behaviour:
- Reset, one clock, synchronous and active-high: state=RUN; stall_cnt=0, flush_cnt=0.
- While RST=1: all `*_en`=0, all `flush_*`=0, halted=0.
- Outputs are combinational from the current state and inputs; state and counters are registered.
- States:
  - RUN: normal operation.
  - MEM_WAIT: waiting on a data access.
  - HALTED: terminal; left only by reset.
- Priority in RUN, first match wins:
  1. mem_halt: all enables 0; next state HALTED.
  2. (mem_dREN|mem_dWEN)&!dhit: all enables 0 (full freeze); next state MEM_WAIT; stall_cnt++.
  3. branch_taken: all enables 1; flush_fd=flush_de=flush_em=1; flush_cnt++. This overrides the load-use stall and an ihit miss.
  4. Load-use hazard, defined as ex_dREN & ex_wsel!=0 & (ex_wsel==id_rs | (id_uses_rt & ex_wsel==id_rt)):
     - pc_en=fetch_en=0;
     - decode_en=1 with flush_de=1;
     - execute_en=memory_en=1;
     - stall_cnt++.
  5. !ihit:
     - pc_en=0;
     - fetch_en=1 with flush_fd=1;
     - later stages enabled;
     - stall_cnt++.
  6. Otherwise: all enables 1, no flush.
- MEM_WAIT:
  - Holds all enables 0 and increments stall_cnt each cycle until dhit=1.
  - On the dhit cycle, the RUN rules (3)-(6) are evaluated as in RUN, treating dhit as satisfied; next state RUN.
  - A branch_taken held during the wait is acted on in the dhit cycle.
- HALTED: all enables 0, halted=1. Counters frozen. Inputs ignored.
- Register 0 never causes a load-use hazard.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- A reset asserted mid-stall returns the block to RUN in the next cycle and clears both counters.

Decomposition:
- Shared package `pipeline_pkg`:
  - enum `ctrl_state_t` {RUN, MEM_WAIT, HALTED};
  - constant REG_ZERO;
  - struct `latch_ctrl_t` {en, flush} for per-stage bundles.
- One sub-module, `sat_counter` (CNT_W, inc, clr), instantiated twice.

Test Plan:
- Reset behaviour: RST=1 for 2 cycles, then 0 with ihit=1 and no hazards -> during reset all enables 0 and counters 0; first post-reset cycle has all enables 1 and all flushes 0.
- Load-use: ex_dREN=1, ex_wsel=8, id_rs=8, ihit=1 -> exactly one cycle with pc_en=0, fetch_en=0, flush_de=1; stall_cnt=1.
- Load-use suppressed: ex_wsel=0, id_rs=0 -> no stall. Separately, id_rt=8 with id_uses_rt=0 -> no stall.
- Data-memory wait: mem_dREN=1 with dhit held low for 3 cycles, then high -> all enables 0 for 3 cycles (MEM_WAIT), all enables 1 in the dhit cycle; stall_cnt=3.
- Branch with hazard and miss: branch_taken=1 together with a load-use hazard and ihit=0 -> all enables 1; flush_fd=flush_de=flush_em=1; flush_cnt=1; stall_cnt unchanged.
- Halt and saturation: mem_halt=1 -> halted=1 from the next cycle with all enables 0 regardless of inputs; RST clears it. With CNT_W=2, 5 stall cycles -> stall_cnt=3.
